// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide over DATA_WIDTH cycles, stalling the pipeline while it runs.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start_EX,
  input  logic [2:0]            i_op_EX,
  input  logic [DATA_WIDTH-1:0] i_srcA_EX,
  input  logic [DATA_WIDTH-1:0] i_srcB_EX,
  input  logic                  i_flush_EX,
  output logic                  o_busy_EX,
  output logic                  o_done_EX,
  output logic [DATA_WIDTH-1:0] o_result_EX
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);
  localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t          state;
  logic [2:0]      op_reg;
  logic [W-1:0]    src_a_reg;
  logic [W-1:0]    src_b_reg;
  logic [W-1:0]    mag_a_reg;
  logic [W-1:0]    mag_b_reg;
  logic            sign_a_reg;
  logic            sign_b_reg;
  logic [2*W-1:0]  acc_reg;
  logic [W-1:0]    rem_reg;
  logic [CW-1:0]   cnt_reg;
  logic            done_reg;
  logic [W-1:0]    result_reg;

  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic            div_zero;
  logic            div_ovf;
  logic [W-1:0]    special_result;
  logic [W:0]      mul_sum;
  logic [W:0]      div_shift;
  logic [W:0]      div_diff;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    quo_fix;
  logic [W-1:0]    rem_fix;
  logic [W-1:0]    fix_result;

  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed.
  assign a_signed = (op_reg == 3'b001) | (op_reg == 3'b010) | (op_reg == 3'b100) | (op_reg == 3'b110);
  assign b_signed = (op_reg == 3'b001) | (op_reg == 3'b100) | (op_reg == 3'b110);
  assign a_neg    = a_signed & src_a_reg[W-1];
  assign b_neg    = b_signed & src_b_reg[W-1];
  assign mag_a    = a_neg ? -src_a_reg : src_a_reg;
  assign mag_b    = b_neg ? -src_b_reg : src_b_reg;

  assign div_zero = op_reg[2] & (src_b_reg == '0);
  assign div_ovf  = op_reg[2] & ~op_reg[0] & (src_a_reg == MIN_NEG) & (src_b_reg == {W{1'b1}});
  assign special_result = div_zero ? (op_reg[1] ? src_a_reg : {W{1'b1}})
                                   : (op_reg[1] ? {W{1'b0}} : MIN_NEG);

  // Multiply: multiplicand in mag_a, multiplier shifts out of mag_b.
  // Divide: dividend shifts out of mag_a, quotient shifts into the low accumulator half.
  assign mul_sum   = {1'b0, acc_reg[2*W-1:W]} + {1'b0, (mag_b_reg[0] ? mag_a_reg : {W{1'b0}})};
  assign div_shift = {rem_reg, mag_a_reg[W-1]};
  assign div_diff  = div_shift - {1'b0, mag_b_reg};

  assign prod    = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
  assign quo_fix = (sign_a_reg ^ sign_b_reg) ? -acc_reg[W-1:0] : acc_reg[W-1:0];
  assign rem_fix = sign_a_reg ? -rem_reg : rem_reg;

  always_comb begin
    fix_result = prod[W-1:0];
    case (op_reg)
      3'b000:                 fix_result = prod[W-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod[2*W-1:W];
      3'b100, 3'b101:         fix_result = quo_fix;
      default:                fix_result = rem_fix;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      op_reg     <= '0;
      src_a_reg  <= '0;
      src_b_reg  <= '0;
      mag_a_reg  <= '0;
      mag_b_reg  <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      acc_reg    <= '0;
      rem_reg    <= '0;
      cnt_reg    <= '0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      if (i_flush_EX) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (i_start_EX) begin
              op_reg    <= i_op_EX;
              src_a_reg <= i_srcA_EX;
              src_b_reg <= i_srcB_EX;
              state     <= PREP;
            end
          end
          PREP: begin
            mag_a_reg  <= mag_a;
            mag_b_reg  <= mag_b;
            sign_a_reg <= a_neg;
            sign_b_reg <= b_neg;
            acc_reg    <= '0;
            rem_reg    <= '0;
            cnt_reg    <= '0;
            if (div_zero | div_ovf) begin
              result_reg <= special_result;
              done_reg   <= 1'b1;
              state      <= DONE;
            end else begin
              state <= RUN;
            end
          end
          RUN: begin
            if (op_reg[2]) begin
              mag_a_reg <= mag_a_reg << 1;
              acc_reg[W-1:0] <= {acc_reg[W-2:0], ~div_diff[W]};
              if (!div_diff[W]) begin
                rem_reg <= div_diff[W-1:0];
              end else begin
                rem_reg <= div_shift[W-1:0];
              end
            end else begin
              acc_reg   <= {mul_sum, acc_reg[W-1:1]};
              mag_b_reg <= mag_b_reg >> 1;
            end
            cnt_reg <= cnt_reg + CW'(1);
            if (cnt_reg == LAST_CNT) begin
              state <= FIX;
            end
          end
          FIX: begin
            result_reg <= fix_result;
            done_reg   <= 1'b1;
            state      <= DONE;
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_busy_EX   = i_start_EX & (state != DONE) & ~i_flush_EX;
  assign o_done_EX   = done_reg;
  assign o_result_EX = result_reg;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide sequencer for the RV32M instructions, sitting beside `stage_execute` in the EX stage. It takes the forwarded ALU source operands at issue and runs a shift-add multiply or a restoring divide over DATA_WIDTH cycles. While it runs, it holds the pipeline through a stall request to the hazard unit. When finished, it delivers one result for the EX/M register.

## Interface
- `DATA_WIDTH`, default 32: operand and result width.
- `i_clk`  in  1  sole clock, rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_start_EX`  in  1  an M-extension instruction is in EX. Held high for as long as it is stalled there.
- `i_op_EX`  in  3  funct3:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `i_srcA_EX`  in  DATA_WIDTH  forwarded rs1 operand.
- `i_srcB_EX`  in  DATA_WIDTH  forwarded rs2 operand.
- `i_flush_EX`  in  1  kill the instruction in EX.
- `o_busy_EX`  out  1  stall request to the hazard unit.
- `o_done_EX`  out  1  one-cycle result-valid pulse.
- `o_result_EX`  out  DATA_WIDTH  result (rd value).

## Operation
- FSM states: IDLE, PREP, RUN, FIX, DONE.
- IDLE:
  - If `i_start_EX` = 1 and `i_flush_EX` = 0, capture `i_op_EX`, `i_srcA_EX` and `i_srcB_EX` into internal registers and go to PREP.
  - Input changes after capture are ignored, because the forwarding sources move while the pipeline is stalled.
- PREP:
  - Take operand magnitudes per op signedness: MULH both signed, MULHSU rs1 signed, DIV/REM both signed.
  - Record the result sign.
  - Clear the 2×DATA_WIDTH accumulator and the iteration counter.
  - Divide by zero or signed overflow (0x80000000 / -1) loads the special result and goes directly to DONE. Otherwise go to RUN.
- RUN: exactly DATA_WIDTH iterations, counter 0 to DATA_WIDTH-1, then go to FIX.
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper half; shift right by 1.
  - Divide (restoring): shift the remainder:quotient pair left by 1; trial-subtract the divisor; on non-negative, keep the difference and set quotient bit 0.
- FIX: apply sign correction and select the output, then go to DONE.
  - Product is negated when the operand signs differ. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - DIV quotient is negated when signs differ. REM remainder takes the dividend's sign.
- DONE:
  - `o_done_EX` = 1; `o_result_EX` is valid.
  - Always return to IDLE. `i_start_EX` seen in DONE belongs to the completing instruction and is ignored.
- Special results:
  - DIV/DIVU by 0 gives all ones; REM/REMU by 0 gives the dividend.
  - DIV overflow gives 0x80000000; REM overflow gives 0.
- `o_busy_EX` = `i_start_EX` & (state != DONE) & ~`i_flush_EX`. It is combinational so the stall is asserted in the issue cycle itself.
- `o_result_EX` is registered, updated only on entry to DONE, and holds its value until the next result.
- `i_flush_EX` = 1 in any state: next state is IDLE, no DONE pulse, result register untouched. Flush has priority over start.

## Timing
- Issue cycle N: state IDLE, `i_start_EX` = 1.
- Normal op:
  - PREP at N+1, RUN N+2..N+33, FIX N+34, DONE N+35.
  - `o_busy_EX` high N..N+34, low at N+35, when the pipeline advances.
- Special-case op: PREP at N+1, DONE at N+2; busy high N..N+1.
- Back-to-back: DONE at cycle D with the next M instruction in EX at D+1 gives a new issue at D+1. There are no dead cycles beyond the DONE cycle.
- Reset values: state IDLE, `o_done_EX` = 0, `o_result_EX` = 0, all internal registers 0. `o_busy_EX` follows its equation.
- Reset asserted mid-operation: immediate return to IDLE; no done pulse after release.
- Width rules:
  - Accumulator is 2×DATA_WIDTH.
  - Divide remainder path is DATA_WIDTH+1 bits, so the trial subtraction borrow is visible.
  - Counter is clog2(DATA_WIDTH) bits; the terminal count is DATA_WIDTH-1.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) issued at N: busy high N..N+34; done only at N+35 with result 0xFFFFFFEB.
- Upper-half multiplies with operands 0x80000000 × 0x80000000:
  - MULH gives 0x40000000.
  - MULHU gives 0x40000000.
  - MULHSU with rs1 0xFFFFFFFF, rs2 0xFFFFFFFF gives 0xFFFFFFFF.
- Divides at 35-cycle latency:
  - DIVU 100/7 gives 14; REMU gives 2.
  - DIV −7/2 gives 0xFFFFFFFD; REM gives 0xFFFFFFFF.
- Special cases, done at N+2:
  - DIV 5/0 gives 0xFFFFFFFF; REM 5/0 gives 5.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM gives 0.
- Operand and flush handling:
  - Operands change at N+3: no effect on the result.
  - Flush at N+10: no done pulse and the result register is unchanged. A new MUL issued at N+12 completes at N+47.
  - Reset pulse mid-RUN: all outputs 0, state IDLE.
- Back-to-back MUL then DIVU: second issue at the cycle after the first DONE, second done 35 cycles later.
